// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out receiver. It assembles DATA_SIZE-bit words from a qualified bit
// stream into a one-deep valid/ready output register. A sticky overrun flag records dropped words.
module serial_word_receiver #(
  parameter int DATA_SIZE = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 word_ready,
  output logic                 word_valid,
  output logic [DATA_SIZE-1:0] word_data,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state, state_nx;
  logic [DATA_SIZE-1:0] sh, sh_nx, shifted;
  logic [CW-1:0]        count, count_nx;
  logic [DATA_SIZE-1:0] data_nx;
  logic                 valid_nx, ovr_nx, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      count      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      sh         <= sh_nx;
      count      <= count_nx;
      word_data  <= data_nx;
      word_valid <= valid_nx;
      overrun    <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    count_nx = count;
    data_nx  = word_data;
    valid_nx = word_valid;
    ovr_nx   = overrun;
    done     = 1'b0;
    shifted  = MSB_FIRST ? {sh[DATA_SIZE-2:0], bit_in} : {bit_in, sh[DATA_SIZE-1:1]};

    // Abort only acts in RECV, so a start arriving with abort in IDLE still starts a frame.
    if (abort && state == RECV) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = RECV;
      count_nx = '0;
      sh_nx    = '0;
      ovr_nx   = 1'b0;
    end else if (state == RECV && bit_valid) begin
      sh_nx = shifted;
      if (count == LAST) begin
        count_nx = '0;
        done     = 1'b1;
      end else begin
        count_nx = count + 1'b1;
      end
    end

    if (done) begin
      if (!word_valid || word_ready) begin
        data_nx  = shifted;
        valid_nx = 1'b1;
      end else begin
        ovr_nx = 1'b1;
      end
    end else if (word_valid && word_ready) begin
      valid_nx = 1'b0;
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: an LSB-first and an MSB-first instance share one stimulus
// stream and are checked against a bit-list reference model.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, bit_valid, bit_in, word_ready;
  logic       l_valid, l_busy, l_ovr, m_valid_o, m_busy, m_ovr;
  logic [7:0] l_data, m_data;

  int total = 0;
  int bad   = 0;

  // Reference model: the received bits of the current frame, kept as a list.
  int         m_bits[$];
  logic       md_busy, md_valid, md_ovr;
  logic [7:0] md_lsb, md_msb;

  always #5 clk = ~clk;

  serial_word_receiver #(.DATA_SIZE(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_in(bit_in), .word_ready(word_ready), .word_valid(l_valid), .word_data(l_data),
    .busy(l_busy), .overrun(l_ovr));

  serial_word_receiver #(.DATA_SIZE(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_in(bit_in), .word_ready(word_ready), .word_valid(m_valid_o), .word_data(m_data),
    .busy(m_busy), .overrun(m_ovr));

  task automatic model_reset();
    m_bits.delete();
    md_busy = 0; md_valid = 0; md_ovr = 0; md_lsb = 0; md_msb = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then settle 1 time unit.
  task automatic step(input logic st, input logic ab, input logic bv, input logic bi,
                      input logic rdy);
    int wl, wm;
    logic done;
    @(negedge clk);
    start = st; abort = ab; bit_valid = bv; bit_in = bi; word_ready = rdy;
    @(posedge clk);
    done = 0; wl = 0; wm = 0;
    if (ab && md_busy) begin
      md_busy = 0;
      m_bits.delete();
    end else if (st) begin
      md_busy = 1;
      m_bits.delete();
      md_ovr = 0;
    end else if (md_busy && bv) begin
      m_bits.push_back(int'(bi));
      if (m_bits.size() == 8) begin
        done = 1;
        foreach (m_bits[i]) begin
          wl += m_bits[i] * (1 << i);
          wm += m_bits[i] * (1 << (7 - i));
        end
        m_bits.delete();
      end
    end
    if (done) begin
      if (!md_valid || rdy) begin
        md_valid = 1; md_lsb = 8'(wl); md_msb = 8'(wm);
      end else begin
        md_ovr = 1;
      end
    end else if (md_valid && rdy) begin
      md_valid = 0;
    end
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic last_rdy,
                           input int max_gap);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < g; k++) begin
        step(0, 0, 0, 1'($urandom), rdy);
        if (max_gap > 0) begin
          total++;
          if (m_busy !== 1'b1) begin
            bad++; $display("FAIL gap_busy got=%b exp=1", m_busy);
          end
        end
      end
      step(0, 0, 1, w[i], (i == 7) ? last_rdy : rdy);
      if (max_gap > 0) begin
        total++;
        if (m_busy !== 1'b1) begin
          bad++; $display("FAIL bit_busy got=%b exp=1", m_busy);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0; word_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if ({l_valid, l_busy, l_ovr, l_data, m_valid_o, m_busy, m_ovr, m_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b_%b_%b_%h_%b_%b_%b_%h exp=all zero",
               l_valid, l_busy, l_ovr, l_data, m_valid_o, m_busy, m_ovr, m_data);
    end
    rst_n = 1;
  endtask

  task automatic test_lsb_basic();
    step(1, 0, 0, 0, 1);
    send_word(8'hA5, 1, 1, 0);
    total++;
    if (l_data !== 8'hA5 || l_valid !== 1'b1) begin
      bad++; $display("FAIL lsb_word got=%h/%b exp=a5/1", l_data, l_valid);
    end
    total++;
    if (m_data !== md_msb) begin
      bad++; $display("FAIL lsb_msbinst got=%h exp=%h", m_data, md_msb);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (l_valid !== 1'b0 || l_data !== 8'hA5) begin
      bad++; $display("FAIL lsb_one_cycle got=%b/%h exp=0/a5", l_valid, l_data);
    end
  endtask

  task automatic test_msb_gaps();
    step(1, 0, 0, 0, 1);
    send_word(8'hA5, 1, 1, 3);
    total++;
    if (m_data !== 8'hA5 || m_valid_o !== 1'b1) begin
      bad++; $display("FAIL msb_word got=%h/%b exp=a5/1", m_data, m_valid_o);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 0, 0, 0);
    total++;
    if (l_data !== 8'h3C || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      bad++; $display("FAIL ovr_first got=%h/%b/%b exp=3c/1/0", l_data, l_valid, l_ovr);
    end
    send_word(8'hC3, 0, 0, 0);
    total++;
    if (l_data !== 8'h3C || l_ovr !== 1'b1 || m_ovr !== 1'b1) begin
      bad++; $display("FAIL ovr_drop got=%h/%b/%b exp=3c/1/1", l_data, l_ovr, m_ovr);
    end
    total++;
    if (m_data !== md_msb) begin
      bad++; $display("FAIL ovr_msbinst got=%h exp=%h", m_data, md_msb);
    end
    step(1, 0, 0, 0, 0);
    total++;
    if (l_ovr !== 1'b0 || l_valid !== 1'b1 || l_busy !== 1'b1) begin
      bad++; $display("FAIL ovr_clear got=%b/%b/%b exp=0/1/1", l_ovr, l_valid, l_busy);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 0, 1);
    send_word(8'h11, 0, 0, 0);
    total++;
    if (l_data !== 8'h11 || l_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%h/%b exp=11/1", l_data, l_valid);
    end
    send_word(8'h22, 0, 1, 0);
    total++;
    if (l_data !== 8'h22 || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      bad++; $display("FAIL b2b_swap got=%h/%b/%b exp=22/1/0", l_data, l_valid, l_ovr);
    end
    total++;
    if (m_data !== md_msb || m_valid_o !== 1'b1) begin
      bad++; $display("FAIL b2b_msbinst got=%h/%b exp=%h/1", m_data, m_valid_o, md_msb);
    end
  endtask

  task automatic test_abort();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1'($urandom), 0);
    step(0, 1, 0, 0, 0);
    total++;
    if (l_busy !== 1'b0 || l_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=%b/%b exp=0/0", l_busy, l_valid);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);
    total++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0) begin
      bad++; $display("FAIL abort_ignored got=%b/%b exp=0/0", l_valid, l_busy);
    end
    step(1, 0, 0, 0, 0);
    send_word(8'h0F, 1, 1, 0);
    total++;
    if (l_data !== 8'h0F || l_valid !== 1'b1) begin
      bad++; $display("FAIL abort_next got=%h/%b exp=0f/1", l_data, l_valid);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 1);
    send_word(8'h55, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1'($urandom), 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    total++;
    if ({l_valid, l_busy, l_ovr, l_data, m_valid_o, m_busy, m_data} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b_%b_%b_%h_%b_%b_%h exp=all zero",
               l_valid, l_busy, l_ovr, l_data, m_valid_o, m_busy, m_data);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1'($urandom), 0);
    total++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0 || l_data !== 8'h00) begin
      bad++; $display("FAIL post_reset_ignore got=%b/%b/%h exp=0/0/00", l_valid, l_busy, l_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      total++;
      if ({l_valid, l_busy, l_ovr, l_data} !== {md_valid, md_busy, md_ovr, md_lsb} ||
          {m_valid_o, m_busy, m_ovr, m_data} !== {md_valid, md_busy, md_ovr, md_msb}) begin
        bad++;
        $display("FAIL rand_cycle%0d got v/b/o/l/m=%b%b%b/%h/%h exp=%b%b%b/%h/%h", n,
                 l_valid, l_busy, l_ovr, l_data, m_data, md_valid, md_busy, md_ovr,
                 md_lsb, md_msb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_gaps();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
